// File: rtl/cordic_rot_engine.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, producing cos/sin of an angle.
// Start/ready handshake upstream, one-cycle done pulse with held results downstream.
module cordic_rot_engine #(
    parameter int unsigned Width = 16,
    parameter int unsigned Iters = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic signed [Width-1:0] angle_i,
    output logic                    ready_o,
    output logic                    done_o,
    output logic signed [Width-1:0] cos_o,
    output logic signed [Width-1:0] sin_o
);

    localparam int unsigned Ext  = Width + 2;
    localparam int unsigned CntW = (Iters > 1) ? $clog2(Iters) : 1;
    localparam real         Scale = 2.0 ** (Width - 2);

    localparam logic signed [Ext-1:0] KGain  = Ext'(int'(0.6072529350 * Scale));
    localparam logic signed [Ext-1:0] PosLim = Ext'(int'(1.5707963267948966 * Scale));
    localparam logic signed [Ext-1:0] NegLim = -PosLim;
    localparam logic signed [Ext-1:0] SatMax = {3'b000, {(Width-1){1'b1}}};
    localparam logic signed [Ext-1:0] SatMin = {3'b111, {(Width-1){1'b0}}};
    localparam logic [CntW-1:0]       LastIt = CntW'(Iters - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic int atan_q(input int i);
        return int'($atan(2.0 ** (-i)) * Scale);
    endfunction

    function automatic logic signed [Width-1:0] sat(input logic signed [Ext-1:0] v);
        if (v > SatMax) return SatMax[Width-1:0];
        if (v < SatMin) return SatMin[Width-1:0];
        return v[Width-1:0];
    endfunction

    // Arctangent table, fixed at elaboration.
    logic signed [Ext-1:0] atan_tab [Iters];
    for (genvar g = 0; g < Iters; g++) begin : g_atan
        localparam int AtanVal = atan_q(g);
        assign atan_tab[g] = Ext'(AtanVal);
    end

    state_e state_q, state_d;
    logic signed [Ext-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic [CntW-1:0]         i_q, i_d;
    logic signed [Width-1:0] cos_q, cos_d, sin_q, sin_d;

    logic signed [Ext-1:0] x_shr, y_shr, x_nxt, y_nxt, z_nxt, ang_ext, ang_clamp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (i_q == LastIt) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_o = (state_q == StIdle);
        done_o  = (state_q == StDone);
    end

    always_comb begin
        x_shr = x_q >>> i_q;
        y_shr = y_q >>> i_q;
        // z < 0 rotates clockwise (d = -1).
        if (z_q[Ext-1]) begin
            x_nxt = x_q + y_shr;
            y_nxt = y_q - x_shr;
            z_nxt = z_q + atan_tab[i_q];
        end else begin
            x_nxt = x_q - y_shr;
            y_nxt = y_q + x_shr;
            z_nxt = z_q - atan_tab[i_q];
        end

        ang_ext = {{2{angle_i[Width-1]}}, angle_i};
        if (ang_ext > PosLim)      ang_clamp = PosLim;
        else if (ang_ext < NegLim) ang_clamp = NegLim;
        else                       ang_clamp = ang_ext;
    end

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        i_d   = i_q;
        cos_d = cos_q;
        sin_d = sin_q;
        if (state_q == StIdle && start_i) begin
            x_d = KGain;
            y_d = '0;
            z_d = ang_clamp;
            i_d = '0;
        end else if (state_q == StRun) begin
            x_d = x_nxt;
            y_d = y_nxt;
            z_d = z_nxt;
            if (i_q == LastIt) begin
                i_d   = '0;
                cos_d = sat(x_nxt);
                sin_d = sat(y_nxt);
            end else begin
                i_d = i_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            i_q   <= '0;
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            i_q   <= i_d;
            cos_q <= cos_d;
            sin_q <= sin_d;
        end
    end

    assign cos_o = cos_q;
    assign sin_o = sin_q;

endmodule

// File: tb/tb_cordic_rot_engine.sv
// Self-checking bench for cordic_rot_engine: results compared against real-valued cos/sin
// of the clamped angle, plus handshake timing, reset and start-ignore behaviour.
module tb_cordic_rot_engine;

    localparam int Width   = 16;
    localparam int Iters   = 16;
    localparam int Tol     = 8;
    localparam int RandTol = 10;
    localparam int Bound   = 100;
    localparam int PLim    = 25736;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic signed [Width-1:0] angle;
    logic                    ready;
    logic                    done;
    logic signed [Width-1:0] cos_v;
    logic signed [Width-1:0] sin_v;

    int checks = 0;
    int passes = 0;

    cordic_rot_engine #(
        .Width (Width),
        .Iters (Iters)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .angle_i (angle),
        .ready_o (ready),
        .done_o  (done),
        .cos_o   (cos_v),
        .sin_o   (sin_v)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp_ang(input int a);
        if (a > PLim) return PLim;
        if (a < -PLim) return -PLim;
        return a;
    endfunction

    function automatic int ref_cos(input int a);
        return int'($cos(real'(clamp_ang(a)) / 16384.0) * 16384.0);
    endfunction

    function automatic int ref_sin(input int a);
        return int'($sin(real'(clamp_ang(a)) / 16384.0) * 16384.0);
    endfunction

    function automatic int adiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Issue one start and wait for done; lat = edges from accept to done (-1 on timeout).
    task automatic run_op(input int a, output int c, output int s, output int lat);
        start = 1'b1;
        angle = Width'(a);
        tick();
        start = 1'b0;
        angle = Width'($urandom);
        lat = -1;
        for (int n = 1; n <= Bound; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        c = int'(cos_v);
        s = int'(sin_v);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        angle = '0;
        tick();
        rst = 1'b0;
        checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
        checks++; if (cos_v !== 16'sd0) $display("FAIL reset_cos got %0d want 0", cos_v); else passes++;
        checks++; if (sin_v !== 16'sd0) $display("FAIL reset_sin got %0d want 0", sin_v); else passes++;
    endtask

    task automatic test_directed();
        int angs [5] = '{0, 12868, -12868, 32767, -32768};
        int c, s, lat;
        foreach (angs[k]) begin
            run_op(angs[k], c, s, lat);
            checks++;
            if (lat != Iters) $display("FAIL dir_latency ang=%0d got %0d want %0d", angs[k], lat, Iters);
            else passes++;
            checks++;
            if (adiff(c, ref_cos(angs[k])) > Tol)
                $display("FAIL dir_cos ang=%0d got %0d want %0d", angs[k], c, ref_cos(angs[k]));
            else passes++;
            checks++;
            if (adiff(s, ref_sin(angs[k])) > Tol)
                $display("FAIL dir_sin ang=%0d got %0d want %0d", angs[k], s, ref_sin(angs[k]));
            else passes++;
            tick();
            checks++;
            if (ready !== 1'b1 || done !== 1'b0)
                $display("FAIL dir_ready_after ang=%0d got ready=%b done=%b want 1/0", angs[k], ready, done);
            else passes++;
        end
    endtask

    task automatic test_ignore_start();
        int pc = ref_cos(-32768);
        int ps = ref_sin(-32768);
        int n = 0;
        int unstable = 0;
        int extra = 0;
        bit seen = 1'b0;
        start = 1'b1;
        angle = 16'sd8192;
        tick();
        start = 1'b0;
        checks++; if (ready !== 1'b0) $display("FAIL run_ready got %b want 0", ready); else passes++;
        for (int k = 0; k < 4; k++) begin
            tick();
            n++;
            if (adiff(int'(cos_v), pc) > Tol || adiff(int'(sin_v), ps) > Tol) unstable++;
        end
        start = 1'b1;
        angle = '0;
        tick();
        n++;
        start = 1'b0;
        while (n < Bound) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (adiff(int'(cos_v), pc) > Tol || adiff(int'(sin_v), ps) > Tol) unstable++;
            tick();
            n++;
        end
        checks++; if (unstable != 0) $display("FAIL run_hold got %0d changes want 0", unstable); else passes++;
        checks++; if (!seen || n != Iters) $display("FAIL ign_latency got %0d want %0d", n, Iters); else passes++;
        checks++;
        if (adiff(int'(cos_v), ref_cos(8192)) > Tol)
            $display("FAIL ign_cos got %0d want %0d", cos_v, ref_cos(8192));
        else passes++;
        checks++;
        if (adiff(int'(sin_v), ref_sin(8192)) > Tol)
            $display("FAIL ign_sin got %0d want %0d", sin_v, ref_sin(8192));
        else passes++;
        // Start asserted while in DONE must not be queued.
        start = 1'b1;
        angle = '0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done || !ready) extra++;
        end
        checks++; if (extra != 0) $display("FAIL ign_extra got %0d busy cycles want 0", extra); else passes++;
        checks++;
        if (adiff(int'(cos_v), ref_cos(8192)) > Tol)
            $display("FAIL ign_hold_cos got %0d want %0d", cos_v, ref_cos(8192));
        else passes++;
    endtask

    task automatic test_reset_mid_run();
        int c, s, lat;
        int extra = 0;
        start = 1'b1;
        angle = 16'sd5000;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", ready); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL mid_rst_done got %b want 0", done); else passes++;
        checks++;
        if (cos_v !== 16'sd0 || sin_v !== 16'sd0)
            $display("FAIL mid_rst_results got %0d/%0d want 0/0", cos_v, sin_v);
        else passes++;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done || !ready) extra++;
        end
        checks++; if (extra != 0) $display("FAIL mid_rst_quiet got %0d busy cycles want 0", extra); else passes++;
        run_op(-8192, c, s, lat);
        checks++; if (lat != Iters) $display("FAIL post_rst_latency got %0d want %0d", lat, Iters); else passes++;
        checks++;
        if (adiff(c, ref_cos(-8192)) > Tol || adiff(s, ref_sin(-8192)) > Tol)
            $display("FAIL post_rst_result got %0d/%0d want %0d/%0d", c, s, ref_cos(-8192), ref_sin(-8192));
        else passes++;
        tick();
    endtask

    task automatic test_random();
        int c, s, lat, a;
        logic signed [Width-1:0] r;
        for (int k = 0; k < 24; k++) begin
            r = Width'($urandom);
            a = int'(r);
            run_op(a, c, s, lat);
            checks++;
            if (lat != Iters) $display("FAIL rnd_latency ang=%0d got %0d want %0d", a, lat, Iters);
            else passes++;
            checks++;
            if (adiff(c, ref_cos(a)) > RandTol)
                $display("FAIL rnd_cos ang=%0d got %0d want %0d", a, c, ref_cos(a));
            else passes++;
            checks++;
            if (adiff(s, ref_sin(a)) > RandTol)
                $display("FAIL rnd_sin ang=%0d got %0d want %0d", a, s, ref_sin(a));
            else passes++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int t_last = -1;
        int pulses = 0;
        start = 1'b1;
        angle = '0;
        for (int t = 1; t <= 65; t++) begin
            tick();
            if (t == 40) start = 1'b0;
            if (done) begin
                pulses++;
                checks++;
                if (adiff(int'(cos_v), 16384) > Tol || adiff(int'(sin_v), 0) > Tol)
                    $display("FAIL b2b_result t=%0d got %0d/%0d want 16384/0", t, cos_v, sin_v);
                else passes++;
                checks++;
                if (t_last < 0 && t != Iters + 1)
                    $display("FAIL b2b_first t got %0d want %0d", t, Iters + 1);
                else if (t_last >= 0 && t - t_last != Iters + 2)
                    $display("FAIL b2b_interval got %0d want %0d", t - t_last, Iters + 2);
                else passes++;
                t_last = t;
            end
        end
        checks++; if (pulses != 3) $display("FAIL b2b_pulses got %0d want 3", pulses); else passes++;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        angle = '0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
